// File: rtl/la_pkg.sv
// ---------------------------------------------------------------------------
// la_pkg
// Shared definitions for the logic-analyser capture core.
//   STATE_W    : width of the capture state encoding
//   la_state_e : capture state (IDLE, ARMED, POST, DONE); the encoding is
//                visible to the host on state_o, so the values are fixed
// ---------------------------------------------------------------------------
package la_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } la_state_e;

endpackage

// File: rtl/la_sdp_ram.sv
// ---------------------------------------------------------------------------
// la_sdp_ram
// Simple dual-port capture buffer: one write port, one registered read port.
// Read-first: a read and a write to the same address in one cycle return the
// old contents. The array is deliberately not reset so it maps onto block RAM.
//   i_clock  : clock for both ports
//   i_wrEn   : write strobe
//   i_wrAddr : write address
//   i_wrData : write data
//   i_rdEn   : read strobe, data appears on o_rdData one cycle later
//   i_rdAddr : read address
//   o_rdData : registered read data (holds its value when i_rdEn is low)
// ---------------------------------------------------------------------------
module la_sdp_ram #(
  parameter  int DATA_W = 56,
  parameter  int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clock,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic              i_rdEn,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output logic [DATA_W-1:0] o_rdData
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdData;

  // Both ports share one clocked block; because the read uses the value of
  // r_mem before this edge's non-blocking write lands, a collision is
  // naturally read-first.
  always_ff @(posedge i_clock) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
    if (i_rdEn) begin
      r_rdData <= r_mem[i_rdAddr];
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/la_capture_core.sv
// ---------------------------------------------------------------------------
// la_capture_core
// On-chip logic-analyser capture engine. Samples a probe bus into a circular
// buffer, keeps a programmable number of pre-trigger samples, fills the rest
// of the buffer after the trigger and then stops so a host can read it back.
//   sys_clk, rst_n   : clock and asynchronous active-low reset
//   data_i           : probe bus, registered once before it is stored
//   trig_i           : trigger inputs, registered twice for edge detection
//   arm_i / abort_i  : start a capture / return to IDLE (abort wins)
//   trig_mask_i      : channel participates in the trigger
//   trig_pol_i       : 1 = high/rising, 0 = low/falling
//   trig_edge_i      : 1 = edge-sensitive, 0 = level-sensitive
//   trig_and_i       : 1 = all masked channels must hit, 0 = any of them
//   pre_cnt_i        : samples kept before the trigger sample
//   rd_en_i/rd_addr_i: buffer read request, answered one cycle later on
//                      rd_data_o with rd_valid_o
//   state_o, done_o  : capture state and "capture complete" flag
//   trig_addr_o      : buffer address holding the trigger sample
//   start_addr_o     : buffer address holding the oldest sample
// ---------------------------------------------------------------------------
module la_capture_core
  import la_pkg::*;
#(
  parameter  int DATA_W = 56,
  parameter  int DEPTH  = 1024,
  parameter  int TRIG_N = 2,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  data_i,
  input  logic [TRIG_N-1:0]  trig_i,
  input  logic               arm_i,
  input  logic               abort_i,
  input  logic [TRIG_N-1:0]  trig_mask_i,
  input  logic [TRIG_N-1:0]  trig_pol_i,
  input  logic [TRIG_N-1:0]  trig_edge_i,
  input  logic               trig_and_i,
  input  logic [ADDR_W-1:0]  pre_cnt_i,
  input  logic               rd_en_i,
  input  logic [ADDR_W-1:0]  rd_addr_i,
  output logic [DATA_W-1:0]  rd_data_o,
  output logic               rd_valid_o,
  output logic [STATE_W-1:0] state_o,
  output logic               done_o,
  output logic [ADDR_W-1:0]  trig_addr_o,
  output logic [ADDR_W-1:0]  start_addr_o
);

  localparam logic [ADDR_W:0] PRE_MAX = (ADDR_W+1)'(DEPTH - 1);

  logic [DATA_W-1:0] r_dataQ;
  logic [TRIG_N-1:0] r_trigQ;
  logic [TRIG_N-1:0] r_trigQQ;

  logic [TRIG_N-1:0] r_mask;
  logic [TRIG_N-1:0] r_pol;
  logic [TRIG_N-1:0] r_edge;
  logic              r_and;
  logic [ADDR_W-1:0] r_pre;

  la_state_e         r_state;
  logic [ADDR_W-1:0] r_wrPtr;
  logic [ADDR_W-1:0] r_fill;
  logic [ADDR_W-1:0] r_postRem;
  logic [ADDR_W-1:0] r_trigAddr;
  logic [ADDR_W-1:0] r_startAddr;
  logic              r_done;
  logic              r_rdValid;

  logic [TRIG_N-1:0] w_edgeHit;
  logic [TRIG_N-1:0] w_levelHit;
  logic [TRIG_N-1:0] w_chHit;
  logic              w_hit;
  logic              w_accept;
  logic              w_writing;
  logic [ADDR_W-1:0] w_preClamp;
  logic [ADDR_W-1:0] w_postLen;
  logic [DATA_W-1:0] w_ramRdData;

  // Input stage runs in every state so the edge history is already valid on
  // the first armed cycle. Storing data_q rather than data_i keeps each
  // stored sample aligned with the trigger condition evaluated from trig_q.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dataQ  <= '0;
      r_trigQ  <= '0;
      r_trigQQ <= '0;
    end else begin
      r_dataQ  <= data_i;
      r_trigQ  <= trig_i;
      r_trigQQ <= r_trigQ;
    end
  end

  // Per-channel hit from the latched configuration. An empty mask triggers
  // immediately, which the OR reduction alone would not give.
  assign w_edgeHit  = (r_pol & r_trigQ & ~r_trigQQ) | (~r_pol & ~r_trigQ & r_trigQQ);
  assign w_levelHit = ~(r_trigQ ^ r_pol);
  assign w_chHit    = (r_edge & w_edgeHit) | (~r_edge & w_levelHit);
  assign w_hit      = (r_mask == '0) ? 1'b1 :
                      r_and ? &(w_chHit | ~r_mask) : |(w_chHit & r_mask);

  // At the full address width pre_cnt_i cannot exceed DEPTH-1, but the
  // bound is kept explicit so the post-trigger length can never underflow.
  assign w_preClamp = ({1'b0, pre_cnt_i} > PRE_MAX) ? PRE_MAX[ADDR_W-1:0] : pre_cnt_i;
  assign w_postLen  = ADDR_W'(DEPTH - 1) - r_pre;

  assign w_writing  = (r_state == ARMED) || (r_state == POST);
  assign w_accept   = (r_state == ARMED) && (r_fill == r_pre) && w_hit;

  // Capture state machine. Pre-fill counts samples written since arm and
  // saturates at the requested pre-trigger depth; a trigger is only taken
  // once that many samples are behind the current one, and the post-trigger
  // count then fills exactly the rest of the buffer.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wrPtr     <= '0;
      r_fill      <= '0;
      r_postRem   <= '0;
      r_trigAddr  <= '0;
      r_startAddr <= '0;
      r_done      <= 1'b0;
      r_mask      <= '0;
      r_pol       <= '0;
      r_edge      <= '0;
      r_and       <= 1'b0;
      r_pre       <= '0;
    end else if (abort_i) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (arm_i) begin
            r_state <= ARMED;
            r_wrPtr <= '0;
            r_fill  <= '0;
            r_done  <= 1'b0;
            r_mask  <= trig_mask_i;
            r_pol   <= trig_pol_i;
            r_edge  <= trig_edge_i;
            r_and   <= trig_and_i;
            r_pre   <= w_preClamp;
          end
        end
        ARMED: begin
          r_wrPtr <= r_wrPtr + ADDR_W'(1);
          if (r_fill != r_pre) begin
            r_fill <= r_fill + ADDR_W'(1);
          end
          if (w_accept) begin
            r_trigAddr  <= r_wrPtr;
            r_startAddr <= r_wrPtr - r_pre;
            r_postRem   <= w_postLen;
            if (w_postLen == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= POST;
            end
          end
        end
        POST: begin
          r_wrPtr   <= r_wrPtr + ADDR_W'(1);
          r_postRem <= r_postRem - ADDR_W'(1);
          if (r_postRem == ADDR_W'(1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read valid simply follows the request by one cycle; the RAM output
  // register itself has no reset, so read data is forced to zero whenever
  // no valid read is being presented.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdValid <= 1'b0;
    end else begin
      r_rdValid <= rd_en_i;
    end
  end

  la_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .i_clock  (sys_clk),
    .i_wrEn   (w_writing),
    .i_wrAddr (r_wrPtr),
    .i_wrData (r_dataQ),
    .i_rdEn   (rd_en_i),
    .i_rdAddr (rd_addr_i),
    .o_rdData (w_ramRdData)
  );

  assign rd_data_o    = r_rdValid ? w_ramRdData : '0;
  assign rd_valid_o   = r_rdValid;
  assign state_o      = r_state;
  assign done_o       = r_done;
  assign trig_addr_o  = r_trigAddr;
  assign start_addr_o = r_startAddr;

endmodule
